// File: rtl/coef_zigzag_scan_if.sv
// Coefficient token stream between the zigzag scanner and its consumer.
// The master drives level/run/last under a valid/ready handshake.
interface coef_zigzag_scan_if;
    logic               out_valid;
    logic               out_ready;
    logic signed [14:0] out_level;
    logic [3:0]         out_run;
    logic               out_last;

    modport master (
        output out_valid,
        output out_level,
        output out_run,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_level,
        input  out_run,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/coef_zigzag_scan.sv
// 4x4 zigzag coefficient scanner: CAVLC-style summary plus a reverse-order (level, run) token stream.
// Optional COEF_ZIGZAG_EARLY_ZERO_EN skips the scan for all-zero blocks.
module coef_zigzag_scan (
    input  logic               clk,
    input  logic               rst,
    input  logic               h264_reset,
    input  logic               start,
    input  logic signed [14:0] coef [0:3][0:3],
    output logic               busy,
    output logic               done,
    output logic [4:0]         total_coeff,
    output logic [1:0]         trailing_ones,
    output logic [3:0]         total_zeros,
    coef_zigzag_scan_if.master tok
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic signed [14:0] coef_r      [0:3][0:3];
    logic signed [14:0] buf_level_r [0:15];
    logic [3:0]         buf_run_r   [0:15];
    logic [3:0]         idx_r;
    logic [3:0]         zero_cnt_r;
    logic [3:0]         emit_ptr_r;
    logic [4:0]         cnt_r;
    logic [4:0]         last_nz_r;
    logic [1:0]         t1_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic signed [14:0] out_level_r;
    logic [3:0]         out_run_r;

    logic [3:0]         pos_s;
    logic signed [14:0] cur_s;
    logic               cur_nz_s;
    logic               cur_one_s;
    logic [4:0]         cnt_nxt_s;
    logic [4:0]         last_nz_nxt_s;
    logic [1:0]         t1_nxt_s;
    logic [3:0]         tz_s;
    logic [3:0]         top_idx_s;
    logic signed [14:0] top_level_s;
    logic [3:0]         top_run_s;
    logic [3:0]         next_ptr_s;

    assign tok.out_valid = out_valid_r;
    assign tok.out_last  = out_last_r;
    assign tok.out_level = out_level_r;
    assign tok.out_run   = out_run_r;

    // Scan index -> raster position {row, col}
    function automatic logic [3:0] zz_pos(input logic [3:0] idx);
        case (idx)
            4'd0:    zz_pos = 4'b0000;
            4'd1:    zz_pos = 4'b0001;
            4'd2:    zz_pos = 4'b0100;
            4'd3:    zz_pos = 4'b1000;
            4'd4:    zz_pos = 4'b0101;
            4'd5:    zz_pos = 4'b0010;
            4'd6:    zz_pos = 4'b0011;
            4'd7:    zz_pos = 4'b0110;
            4'd8:    zz_pos = 4'b1001;
            4'd9:    zz_pos = 4'b1100;
            4'd10:   zz_pos = 4'b1101;
            4'd11:   zz_pos = 4'b1010;
            4'd12:   zz_pos = 4'b0111;
            4'd13:   zz_pos = 4'b1011;
            4'd14:   zz_pos = 4'b1110;
            4'd15:   zz_pos = 4'b1111;
            default: zz_pos = 4'b0000;
        endcase
    endfunction

`ifdef COEF_ZIGZAG_EARLY_ZERO_EN
    logic coef_all_zero_s;

    // All-zero detection on the live coefficient input
    always_comb begin
        coef_all_zero_s = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (coef[r][c] != 15'sd0) begin
                    coef_all_zero_s = 1'b0;
                end else begin
                    coef_all_zero_s = coef_all_zero_s;
                end
            end
        end
    end
`endif

    // Per-position scan arithmetic, including the current position's contribution
    always_comb begin
        pos_s     = zz_pos(idx_r);
        cur_s     = coef_r[pos_s[3:2]][pos_s[1:0]];
        cur_nz_s  = (cur_s != 15'sd0);
        cur_one_s = (cur_s == 15'sd1) || (cur_s == -15'sd1);
        top_idx_s = cnt_r[3:0] - 4'd1;
        if (cur_nz_s) begin
            cnt_nxt_s     = cnt_r + 5'd1;
            last_nz_nxt_s = {1'b0, idx_r} + 5'd1;
            top_level_s   = cur_s;
            top_run_s     = zero_cnt_r;
            if (cur_one_s) begin
                t1_nxt_s = (t1_r == 2'd3) ? 2'd3 : t1_r + 2'd1;
            end else begin
                t1_nxt_s = 2'd0;
            end
        end else begin
            cnt_nxt_s     = cnt_r;
            last_nz_nxt_s = last_nz_r;
            t1_nxt_s      = t1_r;
            top_level_s   = buf_level_r[top_idx_s];
            top_run_s     = buf_run_r[top_idx_s];
        end
        if (cnt_nxt_s == 5'd0) begin
            tz_s = 4'd0;
        end else begin
            tz_s = 4'(last_nz_nxt_s - cnt_nxt_s);
        end
        next_ptr_s = emit_ptr_r - 4'd1;
    end

    // Control FSM with registered status, summary and token outputs
    always_ff @(posedge clk) begin
        if (rst || h264_reset) begin
            state_r       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            total_coeff   <= 5'd0;
            trailing_ones <= 2'd0;
            total_zeros   <= 4'd0;
            idx_r         <= 4'd0;
            zero_cnt_r    <= 4'd0;
            emit_ptr_r    <= 4'd0;
            cnt_r         <= 5'd0;
            last_nz_r     <= 5'd0;
            t1_r          <= 2'd0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_level_r   <= 15'sd0;
            out_run_r     <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                buf_level_r[i]         <= 15'sd0;
                buf_run_r[i]           <= 4'd0;
                coef_r[i / 4][i % 4]   <= 15'sd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        coef_r        <= coef;
                        idx_r         <= 4'd0;
                        zero_cnt_r    <= 4'd0;
                        cnt_r         <= 5'd0;
                        last_nz_r     <= 5'd0;
                        t1_r          <= 2'd0;
                        total_coeff   <= 5'd0;
                        trailing_ones <= 2'd0;
                        total_zeros   <= 4'd0;
                        busy          <= 1'b1;
`ifdef COEF_ZIGZAG_EARLY_ZERO_EN
                        if (coef_all_zero_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= SCAN;
                        end
`else
                        state_r <= SCAN;
`endif
                    end
                end
                SCAN: begin
                    idx_r     <= idx_r + 4'd1;
                    cnt_r     <= cnt_nxt_s;
                    t1_r      <= t1_nxt_s;
                    last_nz_r <= last_nz_nxt_s;
                    if (cur_nz_s) begin
                        buf_level_r[cnt_r[3:0]] <= cur_s;
                        buf_run_r[cnt_r[3:0]]   <= zero_cnt_r;
                        zero_cnt_r              <= 4'd0;
                    end else begin
                        zero_cnt_r <= zero_cnt_r + 4'd1;
                    end
                    if (idx_r == 4'd15) begin
                        total_coeff   <= cnt_nxt_s;
                        trailing_ones <= t1_nxt_s;
                        total_zeros   <= tz_s;
                        if (cnt_nxt_s != 5'd0) begin
                            // Highest-frequency entry may be the one being written this edge
                            state_r     <= EMIT;
                            emit_ptr_r  <= cnt_nxt_s[3:0] - 4'd1;
                            out_valid_r <= 1'b1;
                            out_level_r <= top_level_s;
                            out_run_r   <= top_run_s;
                            out_last_r  <= (cnt_nxt_s == 5'd1);
                        end else begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (tok.out_ready) begin
                        if (emit_ptr_r == 4'd0) begin
                            state_r     <= DONE;
                            done        <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_level_r <= 15'sd0;
                            out_run_r   <= 4'd0;
                        end else begin
                            emit_ptr_r  <= next_ptr_s;
                            out_level_r <= buf_level_r[next_ptr_s];
                            out_run_r   <= buf_run_r[next_ptr_s];
                            out_last_r  <= (next_ptr_s == 4'd0);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coef_zigzag_scan.sv
// Self-checking bench for coef_zigzag_scan: expected tokens are queued at stimulus time
// and popped as the DUT transfers them; summary, latency and reset behaviour checked inline.
module tb_coef_zigzag_scan;
    typedef struct {
        logic signed [14:0] level;
        logic [3:0]         run;
        logic               last;
    } tok_t;

    localparam int ZR [16] = '{0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 2, 3, 3};
    localparam int ZC [16] = '{0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 3, 2, 3};

    logic               clk;
    logic               rst;
    logic               h264_reset;
    logic               start;
    logic signed [14:0] coef_in [0:3][0:3];
    logic               busy;
    logic               done;
    logic [4:0]         total_coeff;
    logic [1:0]         trailing_ones;
    logic [3:0]         total_zeros;

    tok_t       exp_q [$];
    logic [4:0] exp_tc;
    logic [1:0] exp_t1;
    logic [3:0] exp_tz;
    int         pass_cnt;
    int         total_cnt;

    coef_zigzag_scan_if tok_if ();

    coef_zigzag_scan dut (
        .clk           (clk),
        .rst           (rst),
        .h264_reset    (h264_reset),
        .start         (start),
        .coef          (coef_in),
        .busy          (busy),
        .done          (done),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .total_zeros   (total_zeros),
        .tok           (tok_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_coef();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_in[r][c] = 15'sd0;
    endtask

    task automatic scramble_coef();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_in[r][c] = 15'($urandom_range(1, 200));
    endtask

    task automatic push_tok(input int level, input int run, input bit last);
        tok_t e;
        e.level = 15'(level);
        e.run   = 4'(run);
        e.last  = last;
        exp_q.push_back(e);
    endtask

    // Reference: walk the zigzag table, collect (level, run), queue them in reverse
    task automatic model_push();
        logic signed [14:0] lv [0:15];
        int rn [0:15];
        int n, z, hi, t1;
        logic signed [14:0] v;
        n = 0; z = 0; hi = -1; t1 = 0;
        for (int i = 0; i < 16; i++) begin
            v = coef_in[ZR[i]][ZC[i]];
            if (v != 15'sd0) begin
                lv[n] = v; rn[n] = z; n++; z = 0; hi = i;
                if (v == 15'sd1 || v == -15'sd1) t1 = (t1 < 3) ? t1 + 1 : 3;
                else t1 = 0;
            end else begin
                z++;
            end
        end
        exp_tc = 5'(n);
        exp_t1 = 2'(t1);
        exp_tz = (n == 0) ? 4'd0 : 4'(hi + 1 - n);
        for (int k = n - 1; k >= 0; k--) push_tok(int'(lv[k]), rn[k], k == 0);
    endtask

    task automatic run_block(input string name, input int stall, input int exp_done_c);
        int c, first_valid, last_xfer, stall_left, n_exp, n_seen, want;
        bit fresh, got_done;
        logic signed [14:0] hl;
        logic [3:0] hr;
        logic hlast;
        tok_t e;
        n_exp = exp_q.size(); n_seen = 0; c = -1; first_valid = -1; last_xfer = -1;
        stall_left = 0; fresh = 1'b1; got_done = 1'b0; hl = 15'sd0; hr = 4'd0; hlast = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; scramble_coef();
        while (!got_done && c < 200) begin
            @(negedge clk); c++;
            if (c == 0) begin
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
                else pass_cnt++;
            end
            start = (c == 5);
            if (tok_if.out_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    total_cnt++;
                    if (c != 16) $display("FAIL %s first_token_cycle: got %0d want 16", name, c);
                    else pass_cnt++;
                end
                if (fresh) begin
                    hl = tok_if.out_level; hr = tok_if.out_run; hlast = tok_if.out_last;
                    stall_left = stall; fresh = 1'b0;
                end else begin
                    total_cnt++;
                    if (tok_if.out_level !== hl || tok_if.out_run !== hr || tok_if.out_last !== hlast)
                        $display("FAIL %s stall_hold: got (%0d,%0d,%b) want (%0d,%0d,%b)", name,
                                 tok_if.out_level, tok_if.out_run, tok_if.out_last, hl, hr, hlast);
                    else pass_cnt++;
                end
                if (stall_left > 0) begin
                    tok_if.out_ready = 1'b0; stall_left--;
                end else begin
                    tok_if.out_ready = 1'b1; n_seen++; last_xfer = c; fresh = 1'b1;
                    total_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s unexpected_token: got (%0d,%0d,%b) want none", name,
                                 tok_if.out_level, tok_if.out_run, tok_if.out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (tok_if.out_level !== e.level || tok_if.out_run !== e.run || tok_if.out_last !== e.last)
                            $display("FAIL %s token: got (%0d,%0d,%b) want (%0d,%0d,%b)", name,
                                     tok_if.out_level, tok_if.out_run, tok_if.out_last, e.level, e.run, e.last);
                        else pass_cnt++;
                    end
                end
            end else begin
                tok_if.out_ready = 1'($urandom_range(0, 1));
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                want = (exp_done_c >= 0) ? exp_done_c : last_xfer + 1;
                total_cnt++;
                if (c != want) $display("FAIL %s done_cycle: got %0d want %0d", name, c, want);
                else pass_cnt++;
                total_cnt++;
                if (total_coeff !== exp_tc || trailing_ones !== exp_t1 || total_zeros !== exp_tz)
                    $display("FAIL %s summary: got tc=%0d t1=%0d tz=%0d want tc=%0d t1=%0d tz=%0d", name,
                             total_coeff, trailing_ones, total_zeros, exp_tc, exp_t1, exp_tz);
                else pass_cnt++;
                total_cnt++;
                if (n_seen != n_exp) $display("FAIL %s token_count: got %0d want %0d", name, n_seen, n_exp);
                else pass_cnt++;
            end
        end
        if (!got_done) begin
            total_cnt++;
            $display("FAIL %s timeout: got no done want done within 200 cycles", name);
        end else begin
            @(negedge clk);
            total_cnt++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL %s return_idle: got done=%b busy=%b want 0 0", name, done, busy);
            else pass_cnt++;
        end
        exp_q.delete();
        start = 1'b0;
        tok_if.out_ready = 1'b1;
    endtask

    task automatic set_basic();
        clear_coef();
        coef_in[0][0] = 15'sd5;
        coef_in[0][1] = -15'sd1;
        coef_in[2][0] = 15'sd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; set_basic();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, tok_if.out_valid, tok_if.out_last, tok_if.out_level, tok_if.out_run,
             total_coeff, trailing_ones, total_zeros} !== 36'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b tc=%0d want all 0",
                     busy, done, tok_if.out_valid, total_coeff);
        else pass_cnt++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_priority: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic(input int stall, input string name);
        set_basic();
        push_tok(1, 1, 1'b0); push_tok(-1, 0, 1'b0); push_tok(5, 0, 1'b1);
        exp_tc = 5'd3; exp_t1 = 2'd1 + 2'd1; exp_tz = 4'd1;
        run_block(name, stall, -1);
    endtask

    task automatic test_all_ones();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_in[r][c] = 15'sd1;
        for (int k = 0; k < 16; k++) push_tok(1, 0, k == 15);
        exp_tc = 5'd16; exp_t1 = 2'd3; exp_tz = 4'd0;
        run_block("all_ones", 0, -1);
    endtask

    task automatic test_single_high();
        clear_coef();
        coef_in[3][3] = -15'sd7;
        push_tok(-7, 15, 1'b1);
        exp_tc = 5'd1; exp_t1 = 2'd0; exp_tz = 4'd15;
        run_block("single_high", 1, -1);
    endtask

    task automatic test_zero_block();
        clear_coef();
        exp_tc = 5'd0; exp_t1 = 2'd0; exp_tz = 4'd0;
`ifdef COEF_ZIGZAG_EARLY_ZERO_EN
        run_block("zero_block", 0, 0);
`else
        run_block("zero_block", 0, 16);
`endif
    endtask

    task automatic test_random();
        for (int b = 0; b < 5; b++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    coef_in[r][c] = ($urandom_range(0, 2) == 0) ? 15'($urandom_range(0, 8)) - 15'sd4 : 15'sd0;
            model_push();
            run_block("random", $urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_mid_scan_reset();
        set_basic();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, tok_if.out_valid, tok_if.out_last, tok_if.out_level, tok_if.out_run,
             total_coeff, trailing_ones, total_zeros} !== 36'd0)
            $display("FAIL scan_reset: got busy=%b done=%b valid=%b want all 0", busy, done, tok_if.out_valid);
        else pass_cnt++;
        test_basic(0, "after_scan_reset");
    endtask

    task automatic test_mid_emit_reset();
        int n;
        set_basic();
        tok_if.out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (tok_if.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        total_cnt++;
        if (tok_if.out_valid !== 1'b1) $display("FAIL emit_wait: got valid=%b want 1", tok_if.out_valid);
        else pass_cnt++;
        h264_reset = 1'b1;
        @(negedge clk);
        h264_reset = 1'b0;
        tok_if.out_ready = 1'b1;
        total_cnt++;
        if ({busy, done, tok_if.out_valid, tok_if.out_last, tok_if.out_level, tok_if.out_run,
             total_coeff, trailing_ones, total_zeros} !== 36'd0)
            $display("FAIL emit_reset: got valid=%b level=%0d tc=%0d t1=%0d tz=%0d want all 0",
                     tok_if.out_valid, tok_if.out_level, total_coeff, trailing_ones, total_zeros);
        else pass_cnt++;
        test_basic(0, "after_emit_reset");
    endtask

    task automatic test_back_to_back();
        test_basic(0, "b2b_first");
        test_single_high();
        test_basic(2, "b2b_third");
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; h264_reset = 1'b0; start = 1'b0;
        tok_if.out_ready = 1'b1;
        clear_coef();
        test_reset();
        test_basic(0, "basic");
        test_all_ones();
        test_single_high();
        test_basic(3, "stall");
        test_zero_block();
        test_random();
        test_mid_scan_reset();
        test_mid_emit_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
